kyber_encrypt: RTL and testbench
================================

KYBER_ENCRYPT -- requirements
Module: kyber_encrypt

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  synchronous active-low reset.
REQ-002 SHALL have parameter Q, default 17, meaning coefficient modulus.
REQ-003 SHALL have port start  input  1  request to encrypt; sampled only in IDLE.
REQ-004 SHALL have port pk_a  input  signed 32 x [1:0][1:0][3:0]  public matrix A; pk_a[i][j] is a degree-3 polynomial.
REQ-005 SHALL have port pk_t  input  signed 32 x [1:0][3:0]  public vector t.
REQ-006 SHALL have port r_vec  input  signed 32 x [1:0][3:0]  ephemeral vector r.
REQ-007 SHALL have port e1_vec  input  signed 32 x [1:0][3:0]  error vector e1.
REQ-008 SHALL have port e2_poly  input  signed 32 x [3:0]  error polynomial e2.
REQ-009 SHALL have port message  input  4  plaintext; message[3-i] drives coefficient i.
REQ-010 SHALL have port ciphertext  output  signed 32 x [1:0][1:0][3:0]  [0][0]=u0, [0][1]=u1, [1][0]=v, [1][1]=all zero.
REQ-011 SHALL have port busy  output  1  high while an encryption is in progress.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL compute u[j] = sum over i of pk_a[i][j]*r_vec[i] + e1_vec[j] (A transposed), and v = sum over i of pk_t[i]*r_vec[i] + e2_poly + 9*m_i, where m_i = message[3-i].
REQ-014 SHALL multiply polynomials in Z_Q[x]/(x^4+1): the product of coefficient a_j and coefficient b_k adds to coefficient (j+k) mod 4, negated when j+k >= 4.
REQ-015 SHALL capture all inputs on the accepting edge and reduce each captured coefficient to [0,Q-1] using ((x mod Q)+Q) mod Q; input changes after acceptance have no effect.
REQ-016 SHALL use a single multiply-accumulate unit performing one coefficient product per cycle, with accumulators at least 16 bits signed.
REQ-017 SHALL implement FSM states IDLE, MAC, RED: IDLE goes to MAC on start; MAC runs 32 products per output polynomial (2 terms x 4 x 4) and then goes to RED; RED runs one cycle, adds e1/e2/message, reduces to [0,Q-1], stores the polynomial, and clears the accumulators.
REQ-018 SHALL process polynomials in the order u0, u1, v; RED after u0 or u1 returns to MAC, and RED after v returns to IDLE.
REQ-019 SHALL have a fixed latency: with start accepted at edge E0, done SHALL be high for exactly one cycle following edge E99 (3 x 33 cycles).
REQ-020 SHALL drive busy high from the edge after E0 through E99, and low in the done cycle.
REQ-021 SHALL update ciphertext outputs only at edge E99, all coefficients simultaneously; outputs SHALL hold their values between completions.
REQ-022 SHALL ignore start while busy, and SHALL accept start during the done cycle (the FSM is already in IDLE), so back-to-back operation is permitted.
REQ-023 SHALL output all ciphertext coefficients in [0,Q-1], and SHALL tie ciphertext[1][1] to 0.

Reset
REQ-024 SHALL, when rst_n=0 at a clock edge, move to IDLE and set busy=0, done=0, all ciphertext coefficients=0, and all accumulators and counters=0.
REQ-025 SHALL, on reset mid-operation, abort the operation with no done pulse and no partial output update.
REQ-026 SHALL ignore start while rst_n=0.

Verification
REQ-027 SHALL be verified by: all inputs zero, message=4'b1010 -> after 99 cycles, done pulse; v=[9,0,9,0]; u0=u1=[0,0,0,0].
REQ-028 SHALL be verified by: pk_a[0][0]=[0,0,0,1] (x^3), r_vec[0]=[0,1,0,0] (x), all else zero -> u0=[16,0,0,0] (negacyclic wrap); u1=v=0.
REQ-029 SHALL be verified by: e1_vec[0]=[-1,-1,-1,-1], all else zero, message=0 -> u0=[16,16,16,16]; u1=0; v=0.
REQ-030 SHALL be verified by: start pulsed at E0, then held high through E60 -> exactly one done pulse at E99; second start accepted in the done cycle yields the next done 100 cycles later.
REQ-031 SHALL be verified by: rst_n=0 at cycle 50 of an operation -> busy=0 and ciphertext=0 next cycle; no done; a new start then completes normally with correct values.
REQ-032 SHALL be verified by: 200 random round trips with pk_t = A*s mod Q (no key error), all e=0, coefficients of s in {-1,0,1}, random message -> the team's decryption block, fed ciphertext and s, returns decimal_value equal to message.

Source files
------------

// File: rtl/kyber_encrypt.sv
// kyber_encrypt -- toy Kyber-style encryption over Z_Q[x]/(x^4+1), rank 2.
//
// Computes u = A^T * r + e1 and v = t^T * r + e2 + 9*m using one shared
// multiply-accumulate unit (one coefficient product per cycle).
//
// Ports
//   clk, rst_n   rising-edge clock, synchronous active-low reset
//   start        encryption request, sampled only while idle
//   pk_a         public matrix A, pk_a[i][j][k] = coefficient k of A[i][j]
//   pk_t         public vector t
//   r_vec        ephemeral vector r
//   e1_vec       error vector e1
//   e2_poly      error polynomial e2
//   message      plaintext bits, message[3-i] drives coefficient i of v
//   ciphertext   [0][0]=u0, [0][1]=u1, [1][0]=v, [1][1]=0
//   busy         high while an encryption is in progress
//   done         one-cycle completion pulse
//   dbg_state    current FSM state (IDLE=0, MAC=1, RED=2)
//
// Handshake: start is a request with no ready/ack; it is taken on any edge
// where the FSM is idle (including the done cycle) and ignored otherwise.
// Completion is signalled by a single-cycle done, 99 edges after acceptance.
module kyber_encrypt #(
    parameter int Q = 17
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic signed [1:0][1:0][3:0][31:0] pk_a,
    input  logic signed [1:0][3:0][31:0]      pk_t,
    input  logic signed [1:0][3:0][31:0]      r_vec,
    input  logic signed [1:0][3:0][31:0]      e1_vec,
    input  logic signed [3:0][31:0]           e2_poly,
    input  logic [3:0]                        message,
    output logic signed [1:0][1:0][3:0][31:0] ciphertext,
    output logic                              busy,
    output logic                              done,
    output logic [1:0]                        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        RED  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Captured, already-reduced operands (all in [0,Q-1]).
    logic signed [15:0] a_r  [2][2][4];
    logic signed [15:0] t_r  [2][4];
    logic signed [15:0] r_r  [2][4];
    logic signed [15:0] e1_r [2][4];
    logic signed [15:0] e2_r [4];
    logic [3:0]         msg_r;          // bit-reversed: msg_r[i] drives coefficient i

    logic signed [15:0] acc  [4];
    logic signed [15:0] u0_r [4];
    logic signed [15:0] u1_r [4];
    logic [4:0]         cnt;            // {term, a coefficient, r coefficient}
    logic [1:0]         pidx;           // 0 = u0, 1 = u1, 2 = v

    function automatic logic signed [15:0] mod_q(input logic signed [31:0] x);
        logic signed [31:0] m;
        m = x % Q;
        if (m < 0) m = m + Q;
        return 16'(m);
    endfunction

    // MAC operand selection and negacyclic destination.
    logic               term;
    logic [1:0]         cj, ck, dst;
    logic [2:0]         jk;
    logic               wrap;
    logic signed [15:0] a_op, b_op, prod;

    always_comb begin
        term = cnt[4];
        cj   = cnt[3:2];
        ck   = cnt[1:0];
        jk   = {1'b0, cj} + {1'b0, ck};
        dst  = jk[1:0];
        // x^4 = -1, so products landing at degree >= 4 are subtracted.
        wrap = jk[2];
        a_op = (pidx == 2'd2) ? t_r[term][cj] : a_r[term][pidx[0]][cj];
        b_op = r_r[term][ck];
        prod = a_op * b_op;
    end

    // Final add of the error term (and message for v) and reduction.
    logic signed [31:0] red_sum [4];
    logic signed [15:0] red_res [4];

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            red_sum[c] = 32'(acc[c]);
            if (pidx == 2'd2)
                red_sum[c] = red_sum[c] + 32'(e2_r[c]) + (msg_r[c] ? 32'sd9 : 32'sd0);
            else
                red_sum[c] = red_sum[c] + 32'(e1_r[pidx[0]][c]);
            red_res[c] = mod_q(red_sum[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MAC;
            MAC:     if (cnt == 5'd31) state_nxt = RED;
            RED:     state_nxt = (pidx == 2'd2) ? IDLE : MAC;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            pidx       <= '0;
            done       <= 1'b0;
            ciphertext <= '0;
            msg_r      <= '0;
            for (int c = 0; c < 4; c++) begin
                acc[c]  <= '0;
                u0_r[c] <= '0;
                u1_r[c] <= '0;
                e2_r[c] <= '0;
                for (int i = 0; i < 2; i++) begin
                    t_r[i][c]  <= '0;
                    r_r[i][c]  <= '0;
                    e1_r[i][c] <= '0;
                    for (int j = 0; j < 2; j++) a_r[i][j][c] <= '0;
                end
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        pidx  <= '0;
                        msg_r <= {message[0], message[1], message[2], message[3]};
                        for (int c = 0; c < 4; c++) begin
                            acc[c]  <= '0;
                            e2_r[c] <= mod_q(e2_poly[c]);
                            for (int i = 0; i < 2; i++) begin
                                t_r[i][c]  <= mod_q(pk_t[i][c]);
                                r_r[i][c]  <= mod_q(r_vec[i][c]);
                                e1_r[i][c] <= mod_q(e1_vec[i][c]);
                                for (int j = 0; j < 2; j++)
                                    a_r[i][j][c] <= mod_q(pk_a[i][j][c]);
                            end
                        end
                    end
                end
                MAC: begin
                    if (wrap) acc[dst] <= acc[dst] - prod;
                    else      acc[dst] <= acc[dst] + prod;
                    cnt <= cnt + 5'd1;
                end
                RED: begin
                    for (int c = 0; c < 4; c++) acc[c] <= '0;
                    case (pidx)
                        2'd0: for (int c = 0; c < 4; c++) u0_r[c] <= red_res[c];
                        2'd1: for (int c = 0; c < 4; c++) u1_r[c] <= red_res[c];
                        default: begin
                            // All outputs change together, only when v is ready.
                            for (int c = 0; c < 4; c++) begin
                                ciphertext[0][0][c] <= 32'(u0_r[c]);
                                ciphertext[0][1][c] <= 32'(u1_r[c]);
                                ciphertext[1][0][c] <= 32'(red_res[c]);
                                ciphertext[1][1][c] <= '0;
                            end
                            done <= 1'b1;
                        end
                    endcase
                    pidx <= (pidx == 2'd2) ? 2'd0 : pidx + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kyber_encrypt.sv
// Bench for kyber_encrypt: a latency-scheduled reference model with an
// expected-result queue, a per-cycle compare process, directed vectors with
// hand-computed results, and decryption round trips.
module tb_kyber_encrypt;

    localparam int Q = 17;

    typedef logic [1:0][1:0][3:0][31:0] mat_t;
    typedef logic [1:0][3:0][31:0]      vec_t;
    typedef logic [3:0][31:0]           poly_t;

    // ---------------- clock / reset / DUT ----------------
    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start   = 1'b0;
    mat_t       pk_a    = '0;
    vec_t       pk_t    = '0;
    vec_t       r_vec   = '0;
    vec_t       e1_vec  = '0;
    poly_t      e2_poly = '0;
    logic [3:0] message = '0;
    mat_t       ciphertext;
    logic       busy, done;
    logic [1:0] dbg_state;

    int   errors = 0;
    int   checks = 0;
    logic cmp_en = 1'b0;
    int   s_key [2][4];

    always #5 clk = ~clk;

    kyber_encrypt #(.Q(Q)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pk_a       (pk_a),
        .pk_t       (pk_t),
        .r_vec      (r_vec),
        .e1_vec     (e1_vec),
        .e2_poly    (e2_poly),
        .message    (message),
        .ciphertext (ciphertext),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic int md(input int x);
        int m;
        m = x % Q;
        if (m < 0) m = m + Q;
        return m;
    endfunction

    // Negacyclic product in Z[x]/(x^4+1), unreduced.
    function automatic void pmul(input int a[4], input int b[4], output int c[4]);
        for (int n = 0; n < 4; n++) c[n] = 0;
        for (int j = 0; j < 4; j++)
            for (int k = 0; k < 4; k++)
                if (j + k < 4) c[j+k]   += a[j] * b[k];
                else           c[j+k-4] -= a[j] * b[k];
    endfunction

    function automatic mat_t enc_model(input mat_t a, input vec_t t, input vec_t r,
                                       input vec_t e1, input poly_t e2, input logic [3:0] msg);
        int   pa[4];
        int   pb[4];
        int   pr[4];
        int   acc[4];
        mat_t ct;
        ct = '0;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 4; c++) acc[c] = 0;
            for (int i = 0; i < 2; i++) begin
                for (int c = 0; c < 4; c++) begin
                    pa[c] = (p < 2) ? md($signed(a[i][p][c])) : md($signed(t[i][c]));
                    pb[c] = md($signed(r[i][c]));
                end
                pmul(pa, pb, pr);
                for (int c = 0; c < 4; c++) acc[c] += pr[c];
            end
            for (int c = 0; c < 4; c++) begin
                if (p < 2) acc[c] += md($signed(e1[p][c]));
                else       acc[c] += md($signed(e2[c])) + (msg[3-c] ? 9 : 0);
                ct[p/2][p%2][c] = 32'(md(acc[c]));
            end
        end
        return ct;
    endfunction

    // w = v - s^T u; each coefficient decodes to 1 when it lies nearer Q/2 than 0.
    function automatic logic [3:0] decrypt(input mat_t ct);
        int su[4];
        int u[4];
        int sj[4];
        int pr[4];
        int w;
        logic [3:0] dec;
        for (int c = 0; c < 4; c++) su[c] = 0;
        for (int j = 0; j < 2; j++) begin
            for (int c = 0; c < 4; c++) begin
                u[c]  = int'(ct[0][j][c]);
                sj[c] = s_key[j][c];
            end
            pmul(sj, u, pr);
            for (int c = 0; c < 4; c++) su[c] += pr[c];
        end
        dec = '0;
        for (int c = 0; c < 4; c++) begin
            w = md(int'(ct[1][0][c]) - su[c]);
            dec[3-c] = (4 * w > Q) && (4 * w < 3 * Q);
        end
        return dec;
    endfunction

    // ---------------- scoreboard model ----------------
    logic [511:0] exp_q[$];
    int           m_left = 0;
    mat_t         m_ct   = '0;
    logic         m_done = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left = 0;
            m_ct   = '0;
            m_done = 1'b0;
            exp_q.delete();
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_ct   = exp_q.pop_front();
                    m_done = 1'b1;
                end
            end else if (start) begin
                exp_q.push_back(enc_model(pk_a, pk_t, r_vec, e1_vec, e2_poly, message));
                m_left = 99;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_done", done, m_done);
            check("cyc_busy", busy, m_left > 0);
            check("cyc_ct", ciphertext, m_ct);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        pk_a = '0; pk_t = '0; r_vec = '0; e1_vec = '0; e2_poly = '0; message = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Returns at the negedge of the done cycle (or after the budget runs out).
    task automatic wait_done(input string name, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 150);
        check({name, "_latency"}, cyc, 100);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        mat_t exp_ct;
        int   cyc;
        int   pa[4];
        int   pb[4];
        int   pr[4];
        int   tsum[4];

        clear_inputs();
        rst_n = 1'b0;
        repeat (3) tick();
        cmp_en = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ct", ciphertext, '0);
        tick();
        rst_n = 1'b1;

        // All-zero inputs, message 1010 -> v = [9,0,9,0].
        message = 4'b1010;
        pulse_start();
        wait_done("t_msg", cyc);
        exp_ct = '0;
        exp_ct[1][0][0] = 32'd9;
        exp_ct[1][0][2] = 32'd9;
        check("t_msg_ct", ciphertext, exp_ct);
        check("t_msg_busy_in_done", busy, 1'b0);

        // x^3 * x = x^4 = -1 -> u0 = [16,0,0,0]; inputs scrambled after acceptance.
        clear_inputs();
        pk_a[0][0][3] = 32'd1;
        r_vec[0][1]   = 32'd1;
        pulse_start();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                for (int c = 0; c < 4; c++) pk_a[i][j][c] = $urandom();
        r_vec[0][0] = 32'd5;
        message     = 4'b1111;
        wait_done("t_wrap", cyc);
        exp_ct = '0;
        exp_ct[0][0][0] = 32'd16;
        check("t_wrap_ct", ciphertext, exp_ct);

        // e1[0] = all -1 -> u0 = [16,16,16,16].
        clear_inputs();
        for (int c = 0; c < 4; c++) e1_vec[0][c] = 32'hFFFF_FFFF;
        pulse_start();
        wait_done("t_e1", cyc);
        exp_ct = '0;
        for (int c = 0; c < 4; c++) exp_ct[0][0][c] = 32'd16;
        check("t_e1_ct", ciphertext, exp_ct);

        // Out-of-range inputs: A[0][1]=18->1, r[0]=-16->1, e2=[34,-35,0,0]->[0,16,0,0], m3=1.
        clear_inputs();
        pk_a[0][1][0] = 32'd18;
        r_vec[0][0]   = 32'hFFFF_FFF0;
        e2_poly[0]    = 32'd34;
        e2_poly[1]    = 32'hFFFF_FFDD;
        message       = 4'b0001;
        pulse_start();
        wait_done("t_red", cyc);
        exp_ct = '0;
        exp_ct[0][1][0] = 32'd1;
        exp_ct[1][0][1] = 32'd16;
        exp_ct[1][0][3] = 32'd9;
        check("t_red_ct", ciphertext, exp_ct);

        // start held high through E60, then a second start in the done cycle.
        clear_inputs();
        pk_a[1][1][2] = 32'd3;
        r_vec[1][1]   = 32'd2;
        pk_t[0][0]    = 32'd5;
        r_vec[0][0]   = 32'd4;
        e1_vec[1][3]  = 32'd7;
        message       = 4'b0110;
        start = 1'b1;
        tick();
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 61) start = 1'b0;
        end while (!done && cyc < 150);
        check("t_hold_latency", cyc, 100);
        message = 4'b1001;
        start   = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t_b2b", cyc);

        // Reset at cycle 50 of an operation, start asserted during reset.
        clear_inputs();
        pk_a[0][0][3] = 32'd1;
        r_vec[0][1]   = 32'd1;
        pulse_start();
        repeat (49) tick();
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        @(negedge clk);
        check("t_abort_busy", busy, 1'b0);
        check("t_abort_done", done, 1'b0);
        check("t_abort_ct", ciphertext, '0);
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        pulse_start();
        wait_done("t_after_rst", cyc);
        exp_ct = '0;
        exp_ct[0][0][0] = 32'd16;
        check("t_after_rst_ct", ciphertext, exp_ct);

        // Round trips: t = A*s, no errors, s in {-1,0,1}.
        for (int n = 0; n < 200; n++) begin
            clear_inputs();
            for (int i = 0; i < 2; i++)
                for (int c = 0; c < 4; c++) begin
                    s_key[i][c] = int'($urandom_range(0, 2)) - 1;
                    r_vec[i][c] = 32'(int'($urandom_range(0, 40)) - 20);
                    for (int j = 0; j < 2; j++)
                        pk_a[i][j][c] = 32'(int'($urandom_range(0, 40)) - 20);
                end
            for (int i = 0; i < 2; i++) begin
                for (int c = 0; c < 4; c++) tsum[c] = 0;
                for (int j = 0; j < 2; j++) begin
                    for (int c = 0; c < 4; c++) begin
                        pa[c] = md($signed(pk_a[i][j][c]));
                        pb[c] = s_key[j][c];
                    end
                    pmul(pa, pb, pr);
                    for (int c = 0; c < 4; c++) tsum[c] += pr[c];
                end
                for (int c = 0; c < 4; c++) pk_t[i][c] = 32'(md(tsum[c]));
            end
            message = 4'($urandom_range(0, 15));
            pulse_start();
            wait_done("rt", cyc);
            check("rt_decrypt", decrypt(ciphertext), message);
        end

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
